// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults and address-decode helpers for the instruction
// memory slice (imem_if, imem_rsp_fifo, imem_pipe).
//   IMEM_*      default parameter values
//   off_w()     byte-offset bits inside one instruction word
//   idx_w()     word-index width for a given depth (at least 1 bit)
//   align_mask  mask of the byte-offset bits that must be zero for a fetch
package imem_pkg;

   localparam int unsigned IMEM_ADDR_W = 64;
   localparam int unsigned IMEM_DATA_W = 32;
   localparam int unsigned IMEM_DEPTH  = 256;
   localparam int unsigned IMEM_RD_LAT = 2;

   function automatic int unsigned off_w(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [63:0] align_mask(input int unsigned data_w);
      return (64'd1 << off_w(data_w)) - 64'd1;
   endfunction

endpackage

// File: rtl/imem_if.sv
// imem_if: fetch request/response handshake plus flush and program-load bus.
//   master : fetch/load initiator (drives requests, flush, loads, RspReady)
//   slave  : instruction memory (drives ReqReady and the response)
interface imem_if import imem_pkg::*; #(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned DEPTH  = IMEM_DEPTH
) ();

   logic                     ReqValid;
   logic                     ReqReady;
   logic [ADDR_W-1:0]        ReqAddr;
   logic                     RspValid;
   logic                     RspReady;
   logic [DATA_W-1:0]        RspData;
   logic                     RspFault;
   logic                     Flush;
   logic                     LdEn;
   logic [idx_w(DEPTH)-1:0]  LdAddr;
   logic [DATA_W-1:0]        LdData;

   modport master (
      output ReqValid, ReqAddr, RspReady, Flush, LdEn, LdAddr, LdData,
      input  ReqReady, RspValid, RspData, RspFault
   );

   modport slave (
      input  ReqValid, ReqAddr, RspReady, Flush, LdEn, LdAddr, LdData,
      output ReqReady, RspValid, RspData, RspFault
   );

endinterface

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous response FIFO (data + fault flag).
//   clk_i, rst_i (sync, active-high), flush_i : clock and clears
//   push_i, push_data_i, push_fault_i         : write side
//   pop_i                                     : consume head (ignored when empty)
//   valid_o, data_o, fault_o                  : head entry, zero when empty
// The caller guarantees no push into a full FIFO unless it pops that cycle.
module imem_rsp_fifo import imem_pkg::*; #(
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned DEPTH  = IMEM_RD_LAT + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              push_fault_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              fault_o
);

   localparam int unsigned PTR_W = idx_w(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  fault_q;
   logic [PTR_W-1:0]  wr_q, rd_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid_o = (count_q != '0);
   assign do_pop  = pop_i && valid_o;
   assign data_o  = valid_o ? data_q[rd_q] : '0;
   assign fault_o = valid_o ? fault_q[rd_q] : 1'b0;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= ptr_inc(wr_q);
         if (do_pop) rd_q <= ptr_inc(rd_q);
         if (push_i && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (do_pop && !push_i) count_q <= count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         data_q[wr_q]  <= push_data_i;
         fault_q[wr_q] <= push_fault_i;
      end
   end

endmodule

// File: rtl/imem_pipe.sv
// imem_pipe: instruction memory with a RD_LAT-cycle fetch pipeline and an
// in-order response FIFO bounding outstanding fetches to FIFO_D.
//   CLK   : clock, all state on rising edge
//   Reset : synchronous, active-high; clears pipeline/FIFO, keeps array
//   bus   : imem_if.slave -- fetch request/response, Flush, program load
module imem_pipe import imem_pkg::*; #(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W,
   parameter int unsigned DEPTH  = IMEM_DEPTH,
   parameter int unsigned RD_LAT = IMEM_RD_LAT,
   parameter int unsigned FIFO_D = RD_LAT + 1
) (
   input  logic   CLK,
   input  logic   Reset,
   imem_if.slave  bus
);

   localparam int unsigned     OFF_W      = off_w(DATA_W);
   localparam int unsigned     IDX_W      = idx_w(DEPTH);
   localparam int unsigned     CNT_W      = $clog2(FIFO_D + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(DATA_W));

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;

   logic              accept, pop, req_ready, rsp_valid;
   logic [ADDR_W-1:0] word_idx;
   logic              s0_f;
   logic [DATA_W-1:0] s0_d;
   logic              push_v, push_f;
   logic [DATA_W-1:0] push_d;
   logic              fifo_valid, fifo_fault;
   logic [DATA_W-1:0] fifo_data;

   assign req_ready = !Reset && !bus.Flush && (outstanding_q < CNT_W'(FIFO_D));
   assign accept    = bus.ReqValid && req_ready;
   assign pop       = rsp_valid && bus.RspReady;

   // The array is read in the accept cycle; a load at the same edge therefore
   // lands after the read and the fetch sees the old word.
   assign word_idx = bus.ReqAddr >> OFF_W;
   assign s0_f     = ((bus.ReqAddr & ALIGN_MASK) != '0) || (word_idx >= ADDR_W'(DEPTH));
   assign s0_d     = s0_f ? '0 : mem_q[word_idx[IDX_W-1:0]];

   always_ff @(posedge CLK) begin
      if (bus.LdEn && !Reset) mem_q[bus.LdAddr] <= bus.LdData;
   end

   // RD_LAT-1 register stages; the FIFO write is the final stage so the head
   // becomes visible exactly RD_LAT cycles after accept.
   if (RD_LAT == 1) begin : g_nopipe
      assign push_v = accept;
      assign push_d = s0_d;
      assign push_f = s0_f;
   end else begin : g_pipe
      localparam int unsigned NSTG = RD_LAT - 1;
      logic [NSTG-1:0]   stg_v_q;
      logic [NSTG-1:0]   stg_f_q;
      logic [DATA_W-1:0] stg_d_q [NSTG];

      always_ff @(posedge CLK) begin
         if (Reset || bus.Flush) begin
            stg_v_q <= '0;
         end else begin
            stg_v_q[0] <= accept;
            for (int unsigned i = 1; i < NSTG; i++) stg_v_q[i] <= stg_v_q[i-1];
         end
         stg_d_q[0] <= s0_d;
         stg_f_q[0] <= s0_f;
         for (int unsigned i = 1; i < NSTG; i++) begin
            stg_d_q[i] <= stg_d_q[i-1];
            stg_f_q[i] <= stg_f_q[i-1];
         end
      end

      assign push_v = stg_v_q[NSTG-1];
      assign push_d = stg_d_q[NSTG-1];
      assign push_f = stg_f_q[NSTG-1];
   end

   imem_rsp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_D)
   ) u_rsp_fifo (
      .clk_i        (CLK),
      .rst_i        (Reset),
      .flush_i      (bus.Flush),
      .push_i       (push_v),
      .push_data_i  (push_d),
      .push_fault_i (push_f),
      .pop_i        (pop),
      .valid_o      (fifo_valid),
      .data_o       (fifo_data),
      .fault_o      (fifo_fault)
   );

   // FIFO only clears at the reset edge, so mask the head while Reset is high.
   assign rsp_valid    = fifo_valid && !Reset;
   assign bus.RspValid = rsp_valid;
   assign bus.RspData  = rsp_valid ? fifo_data : '0;
   assign bus.RspFault = rsp_valid ? fifo_fault : 1'b0;
   assign bus.ReqReady = req_ready;

   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
      else if (pop && !accept) outstanding_d = outstanding_q - CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (Reset || bus.Flush) outstanding_q <= '0;
      else                    outstanding_q <= outstanding_d;
   end

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: self-checking bench for imem_pipe (RD_LAT=2, FIFO_D=3).
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit
// later; expected responses are queued at accept time from a model array.
module tb_imem_pipe;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned FIFO_D = RD_LAT + 1;

   typedef struct {
      logic [31:0] d;
      logic        f;
      int          acc;
   } exp_t;

   logic CLK   = 1'b0;
   logic Reset = 1'b1;
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [31:0] model_mem [DEPTH];

   imem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   imem_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT),
      .FIFO_D (FIFO_D)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic exp_t expect_for(input logic [63:0] a, input int acc);
      exp_t e;
      e.acc = acc;
      if (a[1:0] != 2'b00 || (a >> 2) >= 64'(DEPTH)) begin
         e.d = '0;
         e.f = 1'b1;
      end else begin
         e.d = model_mem[a[9:2]];
         e.f = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.ReqValid = 1'b1; bus.ReqAddr = '0; bus.RspReady = 1'b1;
      bus.Flush = 1'b0; bus.LdEn = 1'b0; bus.LdAddr = '0; bus.LdData = '0;
      repeat (3) tick();
      #1;
      n_checks++;
      if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL reset_reqready: got %b expected 0", bus.ReqReady); end
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL reset_rspvalid: got %b expected 0", bus.RspValid); end
      n_checks++;
      if (bus.RspData !== 32'h0 || bus.RspFault !== 1'b0) begin
         n_fail++; $display("FAIL reset_rspzero: data %h fault %b expected 0/0", bus.RspData, bus.RspFault);
      end
      tick();
      Reset = 1'b0;
      bus.ReqValid = 1'b0;
      #1;
      n_checks++;
      if (bus.ReqReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.ReqReady); end
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL reset_release_rspvalid: got %b expected 0", bus.RspValid); end
      tick();
   endtask

   task automatic load_program();
      logic [31:0] w [4];
      w = '{32'hF84003E9, 32'hF84083EA, 32'hF84103EB, 32'hF84183EC};
      for (int i = 0; i < 4; i++) begin
         bus.LdEn = 1'b1; bus.LdAddr = 8'(i); bus.LdData = w[i];
         tick();
         model_mem[i] = w[i];
      end
      bus.LdEn = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] addrs [4];
      int   sent = 0;
      int   got  = 0;
      exp_t e;
      addrs = '{64'h0, 64'h4, 64'h8, 64'hC};
      bus.RspReady = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         bus.ReqValid = (sent < 4);
         bus.ReqAddr  = (sent < 4) ? addrs[sent] : '0;
         #1;
         if (bus.RspValid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL b2b_spurious: RspValid=1 expected 0");
            end else begin
               e = sb.pop_front();
               got++;
               n_checks++;
               if (bus.RspData !== e.d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
               n_checks++;
               if (bus.RspFault !== e.f) begin n_fail++; $display("FAIL b2b_fault[%0d]: got %b expected %b", got, bus.RspFault, e.f); end
               n_checks++;
               if (cyc - e.acc !== int'(RD_LAT)) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", got, cyc - e.acc, RD_LAT); end
            end
         end
         if (bus.ReqValid && bus.ReqReady) begin
            sb.push_back(expect_for(bus.ReqAddr, cyc));
            sent++;
         end
         tick();
      end
      bus.ReqValid = 1'b0;
      n_checks++;
      if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d responses expected 4", got); end
   endtask

   task automatic test_fault();
      logic [63:0] addrs [3];
      int   sent = 0;
      int   got  = 0;
      exp_t e;
      addrs = '{64'h2, 64'h8, 64'(4 * DEPTH)};
      bus.RspReady = 1'b1;
      for (int c = 0; c < 20 && got < 3; c++) begin
         bus.ReqValid = (sent < 3);
         bus.ReqAddr  = (sent < 3) ? addrs[sent] : '0;
         #1;
         if (bus.RspValid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL fault_spurious: RspValid=1 expected 0");
            end else begin
               e = sb.pop_front();
               got++;
               n_checks++;
               if (bus.RspData !== e.d) begin n_fail++; $display("FAIL fault_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
               n_checks++;
               if (bus.RspFault !== e.f) begin n_fail++; $display("FAIL fault_flag[%0d]: got %b expected %b", got, bus.RspFault, e.f); end
               n_checks++;
               if (cyc - e.acc !== int'(RD_LAT)) begin n_fail++; $display("FAIL fault_latency[%0d]: got %0d expected %0d", got, cyc - e.acc, RD_LAT); end
            end
         end
         if (bus.ReqValid && bus.ReqReady) begin
            sb.push_back(expect_for(bus.ReqAddr, cyc));
            sent++;
         end
         tick();
      end
      bus.ReqValid = 1'b0;
      n_checks++;
      if (got !== 3) begin n_fail++; $display("FAIL fault_count: got %0d responses expected 3", got); end
   endtask

   task automatic test_backpressure();
      int          acc = 0;
      int          got = 0;
      logic        have_hold = 1'b0;
      logic [31:0] hold_d = '0;
      exp_t        e;
      bus.RspReady = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.ReqValid = 1'b1;
         bus.ReqAddr  = 64'(4 * ((acc + 1) % 4));
         #1;
         if (bus.RspValid) begin
            if (have_hold) begin
               n_checks++;
               if (bus.RspData !== hold_d) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", bus.RspData, hold_d); end
            end
            have_hold = 1'b1;
            hold_d    = bus.RspData;
         end
         if (bus.ReqValid && bus.ReqReady) begin
            sb.push_back(expect_for(bus.ReqAddr, cyc));
            acc++;
         end
         tick();
      end
      #1;
      n_checks++;
      if (acc !== int'(FIFO_D)) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", acc, FIFO_D); end
      n_checks++;
      if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", bus.ReqReady); end
      tick();
      bus.ReqValid = 1'b0;
      bus.RspReady = 1'b1;
      for (int c = 0; c < 20 && sb.size() > 0; c++) begin
         #1;
         if (bus.RspValid) begin
            e = sb.pop_front();
            got++;
            n_checks++;
            if (bus.RspData !== e.d) begin n_fail++; $display("FAIL bp_drain_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
            n_checks++;
            if (bus.RspFault !== e.f) begin n_fail++; $display("FAIL bp_drain_fault[%0d]: got %b expected %b", got, bus.RspFault, e.f); end
         end
         tick();
      end
      #1;
      n_checks++;
      if (got !== int'(FIFO_D)) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got, FIFO_D); end
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL bp_after_drain: RspValid got %b expected 0", bus.RspValid); end
      tick();
   endtask

   task automatic test_flush();
      logic [63:0] addrs [2];
      int   acc = 0;
      int   got = 0;
      int   first_acc = -1;
      exp_t e;
      addrs = '{64'h8, 64'hC};
      bus.RspReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.ReqValid = 1'b1;
         bus.ReqAddr  = addrs[i];
         #1;
         if (bus.ReqValid && bus.ReqReady) sb.push_back(expect_for(bus.ReqAddr, cyc));
         tick();
      end
      bus.ReqValid = 1'b1;
      bus.ReqAddr  = 64'h4;
      bus.Flush    = 1'b1;
      #1;
      n_checks++;
      if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL flush_reqready: got %b expected 0", bus.ReqReady); end
      n_checks++;
      if (sb.size() !== 2) begin n_fail++; $display("FAIL flush_inflight: got %0d in flight expected 2", sb.size()); end
      n_checks++;
      if (bus.RspValid !== 1'b1) begin
         n_fail++; $display("FAIL flush_head_valid: got %b expected 1", bus.RspValid);
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (bus.RspData !== e.d) begin n_fail++; $display("FAIL flush_head_data: got %h expected %h", bus.RspData, e.d); end
      end
      tick();
      sb.delete();
      bus.Flush    = 1'b0;
      bus.ReqValid = 1'b0;
      #1;
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL flush_next_rspvalid: got %b expected 0", bus.RspValid); end
      tick();
      #1;
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak: got %b expected 0", bus.RspValid); end
      tick();
      // Outstanding must restart from zero: a full FIFO_D accepts again.
      bus.RspReady = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.ReqValid = 1'b1;
         bus.ReqAddr  = 64'h4;
         #1;
         if (bus.RspValid && first_acc >= 0 && got == 0) begin
            got = 1;
            n_checks++;
            if (cyc - first_acc !== int'(RD_LAT)) begin n_fail++; $display("FAIL flush_refetch_latency: got %0d expected %0d", cyc - first_acc, RD_LAT); end
            n_checks++;
            if (bus.RspData !== 32'hF84083EA) begin n_fail++; $display("FAIL flush_refetch_data: got %h expected F84083EA", bus.RspData); end
         end
         if (bus.ReqValid && bus.ReqReady) begin
            sb.push_back(expect_for(bus.ReqAddr, cyc));
            if (first_acc < 0) first_acc = cyc;
            acc++;
         end
         tick();
      end
      bus.ReqValid = 1'b0;
      n_checks++;
      if (acc !== int'(FIFO_D)) begin n_fail++; $display("FAIL flush_outstanding: got %0d accepts expected %0d", acc, FIFO_D); end
      bus.RspReady = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && sb.size() > 0; c++) begin
         #1;
         if (bus.RspValid) begin
            e = sb.pop_front();
            got++;
            n_checks++;
            if (bus.RspData !== e.d) begin n_fail++; $display("FAIL flush_drain_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
         end
         tick();
      end
      n_checks++;
      if (got !== int'(FIFO_D)) begin n_fail++; $display("FAIL flush_drain_count: got %0d expected %0d", got, FIFO_D); end
   endtask

   task automatic test_collision();
      int   got = 0;
      exp_t e;
      bus.RspReady = 1'b1;
      bus.ReqValid = 1'b1;
      bus.ReqAddr  = 64'h4;
      bus.LdEn     = 1'b1;
      bus.LdAddr   = 8'd1;
      bus.LdData   = 32'h8B0901AD;
      #1;
      n_checks++;
      if (bus.ReqReady !== 1'b1) begin
         n_fail++; $display("FAIL coll_ready: got %b expected 1", bus.ReqReady);
      end else begin
         sb.push_back(expect_for(bus.ReqAddr, cyc));
      end
      tick();
      model_mem[1] = 32'h8B0901AD;
      bus.LdEn = 1'b0;
      bus.ReqAddr = 64'h4;
      #1;
      if (bus.ReqValid && bus.ReqReady) sb.push_back(expect_for(bus.ReqAddr, cyc));
      tick();
      bus.ReqValid = 1'b0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         #1;
         if (bus.RspValid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL coll_spurious: RspValid=1 expected 0");
            end else begin
               e = sb.pop_front();
               got++;
               n_checks++;
               if (bus.RspData !== e.d) begin n_fail++; $display("FAIL coll_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
               n_checks++;
               if (cyc - e.acc < int'(RD_LAT)) begin n_fail++; $display("FAIL coll_early[%0d]: latency %0d expected >= %0d", got, cyc - e.acc, RD_LAT); end
            end
         end
         tick();
      end
      n_checks++;
      if (got !== 2) begin n_fail++; $display("FAIL coll_count: got %0d expected 2", got); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] addrs [4];
      int   sent = 0;
      int   got  = 0;
      exp_t e;
      addrs = '{64'h0, 64'h4, 64'h8, 64'hC};
      bus.RspReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.ReqValid = 1'b1;
         bus.ReqAddr  = addrs[i];
         #1;
         if (bus.ReqValid && bus.ReqReady) sb.push_back(expect_for(bus.ReqAddr, cyc));
         tick();
      end
      Reset = 1'b1;
      sb.delete();
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rspvalid[%0d]: got %b expected 0", i, bus.RspValid); end
         n_checks++;
         if (bus.ReqReady !== 1'b0) begin n_fail++; $display("FAIL rstmid_reqready[%0d]: got %b expected 0", i, bus.ReqReady); end
         tick();
      end
      Reset = 1'b0;
      bus.ReqValid = 1'b0;
      #1;
      n_checks++;
      if (bus.ReqReady !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_ready: got %b expected 1", bus.ReqReady); end
      n_checks++;
      if (bus.RspValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_release_rspvalid: got %b expected 0", bus.RspValid); end
      tick();
      bus.RspReady = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         bus.ReqValid = (sent < 4);
         bus.ReqAddr  = (sent < 4) ? addrs[sent] : '0;
         #1;
         if (bus.RspValid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL rstmid_spurious: RspValid=1 expected 0");
            end else begin
               e = sb.pop_front();
               got++;
               n_checks++;
               if (bus.RspData !== e.d) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h expected %h", got, bus.RspData, e.d); end
            end
         end
         if (bus.ReqValid && bus.ReqReady) begin
            sb.push_back(expect_for(bus.ReqAddr, cyc));
            sent++;
         end
         tick();
      end
      bus.ReqValid = 1'b0;
      n_checks++;
      if (got !== 4) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 4", got); end
   endtask

   initial begin
      #1;
      test_reset();
      load_program();
      test_back_to_back();
      test_fault();
      test_backpressure();
      test_backpressure();
      test_flush();
      test_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests incomplete");
      $fatal(1);
   end

endmodule

// File: doc/imem_pipe.md
IMEM_PIPE -- requirements
Module: imem_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of instruction words stored.
REQ-004 SHALL have parameter RD_LAT, default 2, legal 1..4, meaning array-read pipeline stages.
REQ-005 SHALL have parameter FIFO_D, default RD_LAT+1, meaning response buffer depth and maximum outstanding requests.
REQ-006 SHALL have port CLK, input, 1, meaning the single clock; all state updates on rising edge.
REQ-007 SHALL have port Reset, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have port ReqValid, input, 1, meaning fetch request present.
REQ-009 SHALL have port ReqReady, output, 1, meaning request can be accepted this cycle.
REQ-010 SHALL have port ReqAddr, input, ADDR_W, meaning fetch byte address.
REQ-011 SHALL have port RspValid, output, 1, meaning head response valid.
REQ-012 SHALL have port RspReady, input, 1, meaning consumer takes head response.
REQ-013 SHALL have port RspData, output, DATA_W, meaning fetched instruction.
REQ-014 SHALL have port RspFault, output, 1, meaning the request was misaligned or out of range.
REQ-015 SHALL have port Flush, input, 1, meaning discard all in-flight fetches (branch redirect).
REQ-016 SHALL have port LdEn, input, 1, meaning program-load write enable.
REQ-017 SHALL have port LdAddr, input, clog2(DEPTH), meaning word index for program load.
REQ-018 SHALL have port LdData, input, DATA_W, meaning word to load.

Function
REQ-019 SHALL accept a request in a cycle where ReqValid and ReqReady are both 1.
REQ-020 SHALL drive ReqReady = !Reset && !Flush && (outstanding < FIFO_D), where outstanding counts requests accepted and not yet popped.
REQ-021 SHALL present a request accepted in cycle t at the FIFO head in cycle t+RD_LAT when the FIFO is otherwise empty; it SHALL never be presented earlier.
REQ-022 SHALL pop the head when RspValid and RspReady are both 1, and SHALL hold RspData/RspFault stable while RspValid=1 and RspReady=0.
REQ-023 SHALL return responses strictly in acceptance order.
REQ-024 SHALL, in the same cycle, increment outstanding on accept and decrement it on pop, leaving it unchanged when both occur.
REQ-025 SHALL flag RspFault=1 with RspData=0 when ReqAddr[log2(DATA_W/8)-1:0] != 0 or the word index is >= DEPTH; otherwise RspFault=0 and RspData=array[word index].
REQ-026 SHALL write LdData to array[LdAddr] on a clock edge with LdEn=1 and Reset=0.
REQ-027 SHALL give read-before-write on a same-word load/fetch collision: a fetch whose array read occurs in the same cycle as the load returns the old word.
REQ-028 SHALL, on Flush=1, drop all pipeline entries and FIFO contents and zero outstanding, so that RspValid=0 next cycle; a pop in the Flush cycle SHALL still count as consumed.
REQ-029 SHALL keep full-FIFO backpressure lossless: with RspReady held 0, exactly FIFO_D requests are accepted, then ReqReady=0.
REQ-030 SHALL wrap FIFO read/write pointers modulo FIFO_D with no bubble.

Reset
REQ-031 SHALL, on an edge with Reset=1, clear pipeline valids, FIFO pointers and outstanding; RspValid=0 and ReqReady=0 while Reset=1, and ReqReady=1 in the first cycle after Reset=0.
REQ-032 SHALL leave array contents unaffected by Reset; a reset mid-operation discards in-flight fetches exactly as Flush does.
REQ-033 SHALL drive RspData=0 and RspFault=0 whenever RspValid=0.

Structure
REQ-034 SHALL place default parameter values and the alignment-mask and word-index-width helper constants in package imem_pkg.
REQ-035 SHALL implement the response buffer as sub-module imem_rsp_fifo (synchronous FIFO, depth FIFO_D, with Flush/Reset clear); the array and read pipeline SHALL stay in imem_pipe.

Verification
REQ-036 SHALL cover: load words 0..3 = F84003E9, F84083EA, F84103EB, F84183EC; fetch 0x0,0x4,0x8,0xC back-to-back with RspReady=1 -> responses in order, first at accept+RD_LAT, one per cycle, no fault.
REQ-037 SHALL cover: fetch 0x2 and fetch 4*DEPTH -> RspFault=1, RspData=0 for both, ordering preserved.
REQ-038 SHALL cover: RspReady=0, ReqValid=1 held -> exactly FIFO_D accepts, ReqReady=0; then RspReady=1 -> all FIFO_D responses drain in order with no loss or duplication.
REQ-039 SHALL cover: Flush asserted with 2 requests in flight -> RspValid=0 next cycle, outstanding=0; a new fetch of 0x4 returns F84083EA at accept+RD_LAT.
REQ-040 SHALL cover: LdEn writing word 1 = 8B0901AD in the same cycle as a fetch of 0x4 is read -> old F84083EA returned; the next fetch of 0x4 returns 8B0901AD.
REQ-041 SHALL cover: Reset pulsed mid-stream -> RspValid=0 and ReqReady=0 during reset, ReqReady=1 the cycle after, array contents intact.
